// File: rtl/alu_program_sequencer.sv
// Instruction sequencer: fetches 16-bit words from SRAM and steers the register file and ALU.
// Optional BZ branch support is compiled in when SEQ_BRANCH_EN is defined.
module alu_program_sequencer #(
  parameter int ADDR_W    = 11,
  parameter int MAX_STEPS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              nMemOut,
  output logic              nMemWrite,
  output logic [ADDR_W-1:0] memAdd,
  input  logic [15:0]       memData,
  output logic [4:0]        rSel1,
  output logic [4:0]        rSel2,
  output logic [4:0]        writeSel,
  output logic              we,
  output logic              regDataSel,
  output logic [2:0]        alu_ctrl,
  input  logic              zeroFlag,
  input  logic              overflowFlag,
  input  logic              carryoutFlag,
  input  logic              negativeFlag,
  output logic [3:0]        flags_q,
  output logic [15:0]       instr_count,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_IMM    = 3'd4,
    S_DONE   = 3'd5
`ifdef SEQ_BRANCH_EN
    , S_BR   = 3'd6
`endif
  } state_t;

  localparam logic [15:0]       MAX_CNT = 16'(MAX_STEPS);
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [3:0]        op;
  logic              is_alu, is_ldi, is_halt;
  logic              retire, budget_hit;

  assign op        = ir[15:12];
  assign is_alu    = ~op[3];
  assign is_ldi    = (op == 4'b1000);
  assign is_halt   = (op == 4'b1111);
  assign nMemWrite = 1'b1;
  assign fsm_state = state;

`ifdef SEQ_BRANCH_EN
  logic is_bz;
  assign is_bz = (op == 4'b1001);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Handshake: start is sampled only in IDLE; busy covers FETCH..last retire; done pulses
  // for one cycle with err valid alongside it.
  always_comb begin
    state_nx   = state;
    retire     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    nMemOut    = 1'b1;
    memAdd     = '0;
    rSel1      = '0;
    rSel2      = '0;
    writeSel   = '0;
    we         = 1'b0;
    regDataSel = 1'b0;
    alu_ctrl   = '0;
    case (state)
      S_IDLE: if (start) state_nx = S_FETCH;
      S_FETCH: begin
        busy     = 1'b1;
        nMemOut  = 1'b0;
        memAdd   = pc;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        busy     = 1'b1;
        rSel1    = {1'b0, ir[7:4]};
        rSel2    = {1'b0, ir[3:0]};
        writeSel = {1'b0, ir[11:8]};
        alu_ctrl = ir[14:12];
        if (is_alu)      state_nx = S_EXEC;
        else if (is_ldi) state_nx = S_IMM;
`ifdef SEQ_BRANCH_EN
        else if (is_bz)  state_nx = S_BR;
`endif
        else if (is_halt) begin
          retire   = 1'b1;
          state_nx = S_DONE;
        end else begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        busy     = 1'b1;
        rSel1    = {1'b0, ir[7:4]};
        rSel2    = {1'b0, ir[3:0]};
        writeSel = {1'b0, ir[11:8]};
        alu_ctrl = ir[14:12];
        we       = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_IMM: begin
        busy       = 1'b1;
        nMemOut    = 1'b0;
        memAdd     = pc;
        regDataSel = 1'b1;
        writeSel   = {1'b0, ir[11:8]};
        we         = 1'b1;
        retire     = 1'b1;
        state_nx   = S_FETCH;
      end
`ifdef SEQ_BRANCH_EN
      S_BR: begin
        busy     = 1'b1;
        nMemOut  = 1'b0;
        memAdd   = pc;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Exhausting the instruction budget overrides whatever would have come next.
    budget_hit = retire && ((instr_count + 16'd1) == MAX_CNT);
    if (budget_hit) state_nx = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= '0;
      ir          <= '0;
      flags_q     <= '0;
      instr_count <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pc          <= start_addr;
          instr_count <= '0;
          err         <= 1'b0;
        end
        S_FETCH: begin
          ir <= memData;
          pc <= pc + PC_ONE;
        end
        S_EXEC: flags_q <= {zeroFlag, overflowFlag, carryoutFlag, negativeFlag};
        S_IMM:  pc <= pc + PC_ONE;
`ifdef SEQ_BRANCH_EN
        S_BR:   pc <= flags_q[3] ? memData[ADDR_W-1:0] : pc + PC_ONE;
`endif
        default: ;
      endcase
      if (retire)     instr_count <= instr_count + 16'd1;
      if (budget_hit) err <= 1'b1;
    end
  end

endmodule
